axi_lite_master_bridge: RTL

- Parametrised AXI4-Lite master bridge between the core-side memory request interface and the AXI-Lite interconnect.
- Has independent read and write front-end channels with valid/ready handshakes, and runs one read and one write concurrently.
- Issues AW and W in parallel and reports completion and slave error status back to the requester.
- Configurable data width and protection attributes.

---
 rtl/axi_lite_pkg.sv | 13 +
 rtl/axi_lite_resp_timer.sv | 21 ++
 rtl/axi_lite_master_bridge.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared FSM states, AXI response codes and default PROT for the AXI-Lite master bridge.
package axi_lite_pkg;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} write_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} read_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
  function automatic logic resp_err(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction
endpackage

// File: rtl/axi_lite_resp_timer.sv
// axi_lite_resp_timer: counts cycles waiting for a response and flags expiry at CYCLES-1.
module axi_lite_resp_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic resp,
  output logic expire
);
  localparam int CW = $clog2(CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (active && !resp) ? cnt_q + CW'(1) : '0;
    expire = active && !resp && (cnt_q == CW'(CYCLES - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: core request to AXI4-Lite master with independent read/write FSMs.
// Optional response timeout enabled by defining AXI_LITE_BRIDGE_TIMEOUT_EN.
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [2:0] PROT = PROT_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  output logic              wr_done,
  output logic              wr_err,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic              rd_rsp_err,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
`ifdef AXI_LITE_BRIDGE_TIMEOUT_EN
  , output logic            timeout_seen
`endif
);
  if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("axi_lite_master_bridge: illegal DATA_W or TIMEOUT_CYCLES");
  end
  write_state_t ws_q, ws_d;
  read_state_t rs_q, rs_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd_rsp_data_q, rd_rsp_data_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic wr_done_q, wr_done_d, wr_err_q, wr_err_d;
  logic rd_rsp_valid_q, rd_rsp_valid_d, rd_rsp_err_q, rd_rsp_err_d;
  logic wr_exp, rd_exp;
`ifdef AXI_LITE_BRIDGE_TIMEOUT_EN
  logic timeout_seen_q, timeout_seen_d;
  axi_lite_resp_timer #(.CYCLES(TIMEOUT_CYCLES)) u_wr_timer (
    .clk(ACLK), .rst(!ARESETn), .active(ws_q == W_RESP), .resp(BVALID), .expire(wr_exp)
  );
  axi_lite_resp_timer #(.CYCLES(TIMEOUT_CYCLES)) u_rd_timer (
    .clk(ACLK), .rst(!ARESETn), .active(rs_q == R_DATA), .resp(RVALID), .expire(rd_exp)
  );
  assign timeout_seen_d = timeout_seen_q | wr_exp | rd_exp;
  assign timeout_seen = timeout_seen_q;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) timeout_seen_q <= 1'b0;
    else timeout_seen_q <= timeout_seen_d;
  end
`else
  assign wr_exp = 1'b0;
  assign rd_exp = 1'b0;
`endif
  always_comb begin
    ws_d = ws_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    aw_addr_d = aw_addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wr_done_d = 1'b0;
    wr_err_d = 1'b0;
    case (ws_q)
      W_IDLE: if (wr_req_valid) begin
        ws_d = W_SEND;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
        aw_addr_d = wr_addr;
        wdata_d = wr_data;
        wstrb_d = wr_strb;
      end
      W_SEND: begin
        aw_done_d = aw_done_q | AWREADY;
        w_done_d = w_done_q | WREADY;
        ws_d = (aw_done_d && w_done_d) ? W_RESP : W_SEND;
      end
      W_RESP: if (BVALID || wr_exp) begin
        ws_d = W_IDLE;
        wr_done_d = 1'b1;
        wr_err_d = BVALID ? resp_err(BRESP) : 1'b1;
      end
      default: ws_d = W_IDLE;
    endcase
  end
  always_comb begin
    rs_d = rs_q;
    ar_addr_d = ar_addr_q;
    rd_rsp_data_d = rd_rsp_data_q;
    rd_rsp_valid_d = 1'b0;
    rd_rsp_err_d = 1'b0;
    case (rs_q)
      R_IDLE: if (rd_req_valid) begin
        rs_d = R_ADDR;
        ar_addr_d = rd_addr;
      end
      R_ADDR: rs_d = ARREADY ? R_DATA : R_ADDR;
      R_DATA: if (RVALID || rd_exp) begin
        rs_d = R_IDLE;
        rd_rsp_valid_d = 1'b1;
        rd_rsp_data_d = RVALID ? RDATA : '0;
        rd_rsp_err_d = RVALID ? resp_err(RRESP) : 1'b1;
      end
      default: rs_d = R_IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      ws_q <= W_IDLE;
      rs_q <= R_IDLE;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      aw_addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ar_addr_q <= '0;
      wr_done_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_data_q <= '0;
      rd_rsp_err_q <= 1'b0;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      aw_addr_q <= aw_addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ar_addr_q <= ar_addr_d;
      wr_done_q <= wr_done_d;
      wr_err_q <= wr_err_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      rd_rsp_data_q <= rd_rsp_data_d;
      rd_rsp_err_q <= rd_rsp_err_d;
    end
  end
  assign wr_req_ready = ws_q == W_IDLE;
  assign rd_req_ready = rs_q == R_IDLE;
  assign AWVALID = (ws_q == W_SEND) && !aw_done_q;
  assign WVALID = (ws_q == W_SEND) && !w_done_q;
  assign BREADY = ws_q == W_RESP;
  assign ARVALID = rs_q == R_ADDR;
  assign RREADY = rs_q == R_DATA;
  assign AWADDR = aw_addr_q;
  assign WDATA = wdata_q;
  assign WSTRB = wstrb_q;
  assign ARADDR = ar_addr_q;
  assign AWPROT = PROT;
  assign ARPROT = PROT;
  assign wr_done = wr_done_q;
  assign wr_err = wr_err_q;
  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rd_rsp_data = rd_rsp_data_q;
  assign rd_rsp_err = rd_rsp_err_q;
endmodule
